// File: rtl/lms_weight_bank_if.sv
// Weight-update stream into the LMS weight bank: one signed I/Q update per
// beat, addressed to an array element, with a valid/ready handshake.
interface lms_weight_bank_if #(
  parameter int W  = 18,
  parameter int AW = 2
);
  logic                 upd_valid;
  logic                 upd_ready;
  logic [AW-1:0]        upd_idx;
  logic signed [W-1:0]  updateI;
  logic signed [W-1:0]  updateQ;

  modport master (
    output upd_valid, upd_idx, updateI, updateQ,
    input  upd_ready
  );

  modport slave (
    input  upd_valid, upd_idx, updateI, updateQ,
    output upd_ready
  );
endinterface

// File: rtl/lms_weight_bank.sv
// Complex LMS weight register bank. Updates are staged in S1 for one cycle
// and then accumulated into the addressed weight with saturation; because
// the accumulate reads the weight register itself, back-to-back updates to
// one element need no forwarding. Broadcast init loads every weight over N
// cycles; completion of element N-1 marks the end of a sweep.
//
// state | meaning
// ------+---------------------------------------------------------------
// RUN   | accepting updates (unless init), S1 writes into the bank
// LOAD  | writing init_I/init_Q into weight[k], k = 0..N-1, no updates
module lms_weight_bank #(
  parameter int N  = 4,
  parameter int W  = 18,
  parameter int AW = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                init,
  input  logic signed [W-1:0] init_I,
  input  logic signed [W-1:0] init_Q,
  lms_weight_bank_if.slave    upd,
  input  logic [AW-1:0]       rd_idx,
  output logic signed [W-1:0] wI,
  output logic signed [W-1:0] wQ,
  output logic                sweep_done,
  output logic [15:0]         sweep_cnt,
  output logic                sat_flag,
  output logic                busy
);

  typedef enum logic {ST_RUN, ST_LOAD} state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

  state_t              state_q, state_d;
  logic [AW-1:0]       k_q, k_d;
  logic                load_enter;
  logic                accept;

  logic                s1_valid;
  logic [AW-1:0]       s1_idx;
  logic signed [W-1:0] s1_i, s1_q;

  logic signed [W-1:0] wgt_i [N];
  logic signed [W-1:0] wgt_q [N];

  logic                idx_ok;
  logic                wr_en;
  logic [W:0]          res_i, res_q;

  // Sum in W+1 bits; MSB of the result is the clamp indicator.
  function automatic logic [W:0] sat_add(input logic signed [W-1:0] a,
                                         input logic signed [W-1:0] b);
    logic [W:0]   s;
    logic [W-1:0] v;
    logic         c;
    s = {a[W-1], a} + {b[W-1], b};
    c = (s[W] != s[W-1]);
    if (!c)
      v = s[W-1:0];
    else if (s[W])
      v = {1'b1, {(W-1){1'b0}}};
    else
      v = {1'b0, {(W-1){1'b1}}};
    return {c, v};
  endfunction

  // Indices beyond N only exist when N is not a power of two.
  generate
    if (N == (1 << AW)) begin : g_idx_full
      assign idx_ok = 1'b1;
    end else begin : g_idx_part
      assign idx_ok = (s1_idx <= LAST_IDX);
    end
  endgenerate

  assign accept = upd.upd_valid && upd.upd_ready;
  assign wr_en  = s1_valid && idx_ok;
  assign res_i  = sat_add(wgt_i[s1_idx], s1_i);
  assign res_q  = sat_add(wgt_q[s1_idx], s1_q);

  // State register and load counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  // Next-state, handshake and busy decode; ready never looks at upd_valid.
  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    load_enter    = 1'b0;
    upd.upd_ready = 1'b0;
    busy          = 1'b0;
    case (state_q)
      ST_RUN: begin
        upd.upd_ready = !init;
        if (init) begin
          state_d    = ST_LOAD;
          k_d        = '0;
          load_enter = 1'b1;
        end
      end
      ST_LOAD: begin
        busy = 1'b1;
        k_d  = k_q + AW'(1);
        if (k_q == LAST_IDX) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // S1 stage: capture accepted update beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_idx   <= '0;
      s1_i     <= '0;
      s1_q     <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_idx <= upd.upd_idx;
        s1_i   <= upd.updateI;
        s1_q   <= upd.updateQ;
      end
    end
  end

  // Weight bank: broadcast load in LOAD, saturating accumulate from S1 in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < N; n++) begin
        wgt_i[n] <= '0;
        wgt_q[n] <= '0;
      end
    end else if (state_q == ST_LOAD) begin
      wgt_i[k_q] <= init_I;
      wgt_q[k_q] <= init_Q;
    end else if (wr_en) begin
      wgt_i[s1_idx] <= res_i[W-1:0];
      wgt_q[s1_idx] <= res_q[W-1:0];
    end
  end

  // Sweep and saturation status; entering LOAD clears both counters/flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweep_done <= 1'b0;
      sweep_cnt  <= '0;
      sat_flag   <= 1'b0;
    end else begin
      sweep_done <= wr_en && (s1_idx == LAST_IDX);
      if (load_enter)
        sweep_cnt <= '0;
      else if (wr_en && (s1_idx == LAST_IDX))
        sweep_cnt <= sweep_cnt + 16'd1;
      if (load_enter)
        sat_flag <= 1'b0;
      else if (wr_en && (res_i[W] || res_q[W]))
        sat_flag <= 1'b1;
    end
  end

  // Registered read port, returns the value stored before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wI <= '0;
      wQ <= '0;
    end else begin
      wI <= wgt_i[rd_idx];
      wQ <= wgt_q[rd_idx];
    end
  end

endmodule
